a2d_spi_resp: RTL and testbench



---
 rtl/a2d_pkg.sv | 17 +
 rtl/spi_edge_sync.sv | 34 +++
 rtl/a2d_spi_resp.sv | 131 +++++++++++++
 tb/tb_a2d_spi_resp.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared constants and FSM state type for the A2D SPI responder.
package a2d_pkg;

    localparam int NUM_CH  = 8;
    localparam int RES_W   = 12;
    localparam int FRAME_W = 16;
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int CH_LSB  = 11;
    localparam int CH_MSB  = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        COMMIT = 2'd2
    } resp_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer with a history flop for edge detection of an
// asynchronous SPI input.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic hist;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            hist <= RST_VAL;
        end else begin
            meta <= async_in;
            sync <= meta;
            hist <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~hist;
    assign fall  = ~sync & hist;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit ADC: decodes the channel
// command of one frame and returns that channel's sample in the next frame.
module a2d_spi_resp #(
    parameter int NUM_CH  = a2d_pkg::NUM_CH,
    parameter int RES_W   = a2d_pkg::RES_W,
    parameter int FRAME_W = a2d_pkg::FRAME_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      SS_n,
    input  logic                      SCLK,
    input  logic                      MOSI,
    output logic                      MISO,
    input  logic [NUM_CH*RES_W-1:0]   chan_data,
    output logic                      cmd_vld,
    output logic [$clog2(NUM_CH)-1:0] cmd_chnnl,
    output logic                      frm_err
);

    import a2d_pkg::*;

    localparam int CHW = $clog2(NUM_CH);

    resp_state_t        state, state_nxt;
    logic [FRAME_W-1:0] tx, tx_nxt;
    logic [FRAME_W-1:0] rx, rx_nxt;
    logic [4:0]         cnt, cnt_nxt;
    logic [RES_W-1:0]   res_hold;
    logic [CHW-1:0]     rx_chan;
    logic [1:0]         live;
    logic               armed;
    logic               mosi_meta, mosi_sync;

    logic ss_lvl, ss_rise, ss_fall_unused;
    logic sclk_level_unused, sclk_rise, sclk_fall;

    spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SS_n),
        .level    (ss_lvl),
        .rise     (ss_rise),
        .fall     (ss_fall_unused)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (SCLK),
        .level    (sclk_level_unused),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    assign rx_chan = rx[CH_LSB +: CHW];

    // A frame starts on a low SS_n only once a genuine high has been seen
    // since reset; this also catches a fall that arrives during COMMIT.
    always_comb begin
        state_nxt = state;
        tx_nxt    = tx;
        rx_nxt    = rx;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (armed && !ss_lvl) begin
                    state_nxt = ACTIVE;
                    tx_nxt    = {{(FRAME_W-RES_W){1'b0}}, res_hold};
                    rx_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nxt = COMMIT;
                end else if (sclk_rise) begin
                    rx_nxt = {rx[FRAME_W-2:0], mosi_sync};
                    if (cnt != 5'd31) cnt_nxt = cnt + 5'd1;
                end else if (sclk_fall && cnt != 5'd0) begin
                    tx_nxt = {tx[FRAME_W-2:0], 1'b0};
                end
            end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= '0;
            rx        <= '0;
            cnt       <= '0;
            res_hold  <= '0;
            cmd_chnnl <= '0;
            cmd_vld   <= 1'b0;
            frm_err   <= 1'b0;
            MISO      <= 1'b0;
            live      <= '0;
            armed     <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx        <= tx_nxt;
            rx        <= rx_nxt;
            cnt       <= cnt_nxt;
            MISO      <= (state_nxt == ACTIVE) && tx_nxt[FRAME_W-1];
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
            live      <= {live[0], 1'b1};
            cmd_vld   <= 1'b0;
            frm_err   <= 1'b0;
            if (state == IDLE && state_nxt == ACTIVE) begin
                armed <= 1'b0;
            end else if (live[1] && ss_lvl) begin
                armed <= 1'b1;
            end
            if (state == COMMIT) begin
                if (cnt == 5'(FRAME_W)) begin
                    cmd_chnnl <= rx_chan;
                    res_hold  <= chan_data[rx_chan*RES_W +: RES_W];
                    cmd_vld   <= 1'b1;
                end else begin
                    frm_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed bench for a2d_spi_resp: a behavioural SPI master with a reply
// scoreboard and pulse counters.
module tb_a2d_spi_resp;

    import a2d_pkg::*;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    SS_n  = 1'b1;
    logic                    SCLK  = 1'b1;
    logic                    MOSI  = 1'b0;
    logic                    MISO;
    logic                    cmd_vld;
    logic                    frm_err;
    logic [CH_W-1:0]         cmd_chnnl;
    logic [NUM_CH*RES_W-1:0] chan_data;
    logic [RES_W-1:0]        ch [NUM_CH];

    int checks  = 0;
    int errors  = 0;
    int vld_cnt = 0;
    int err_cnt = 0;

    logic [15:0]     exp_q [$];
    logic [RES_W-1:0] model_hold  = '0;
    logic [CH_W-1:0]  model_chnnl = '0;

    a2d_spi_resp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .chan_data (chan_data),
        .cmd_vld   (cmd_vld),
        .cmd_chnnl (cmd_chnnl),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        chan_data = '0;
        for (int i = 0; i < NUM_CH; i++) chan_data[i*RES_W +: RES_W] = ch[i];
    end

    always @(negedge clk) begin
        if (cmd_vld) vld_cnt++;
        if (frm_err) err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Mode with SCLK idle high: MOSI changes on the fall, both sides sample on the rise.
    task automatic applyStimulus(input logic [15:0] word, input int nbits, input int gap,
                                 input int rst_at, output logic [15:0] rd);
        rd   = '0;
        SS_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                wait_clk(2);
                checkOutput("rst_mid_miso", {31'd0, MISO}, 32'd0);
                checkOutput("rst_mid_state", 32'(dut.state), 32'(IDLE));
                rst_n = 1'b1;
            end
            SCLK = 1'b0;
            MOSI = word[15-i];
            wait_clk(4);
            rd[15-i] = MISO;
            SCLK = 1'b1;
            wait_clk(4);
        end
        SS_n = 1'b1;
        wait_clk(gap);
    endtask

    task automatic frame_and_check(input logic [15:0] word, input int nbits, input int gap,
                                   input bit check_pulses, input string tag);
        logic [15:0] rd, exp, mask;
        int v0, e0;
        exp_q.push_back({4'h0, model_hold});
        v0 = vld_cnt;
        e0 = err_cnt;
        applyStimulus(word, nbits, gap, -1, rd);
        exp  = exp_q.pop_front();
        mask = (nbits >= 16) ? 16'hFFFF : ~(16'hFFFF >> nbits);
        checkOutput({tag, "_reply"}, 32'(rd & mask), 32'(exp & mask));
        if (nbits == 16) begin
            model_chnnl = word[13:11];
            model_hold  = ch[model_chnnl];
        end
        if (check_pulses) begin
            checkOutput({tag, "_vld"}, 32'(vld_cnt - v0), (nbits == 16) ? 32'd1 : 32'd0);
            checkOutput({tag, "_err"}, 32'(err_cnt - e0), (nbits == 16) ? 32'd0 : 32'd1);
            checkOutput({tag, "_chnnl"}, 32'(cmd_chnnl), 32'(model_chnnl));
        end
    endtask

    initial begin
        logic [15:0] rd;
        int v0, e0;

        for (int i = 0; i < NUM_CH; i++) ch[i] = 12'h0A5 + 12'(i) * 12'h101;
        ch[3] = 12'hABC;
        ch[4] = 12'h123;

        wait_clk(4);
        checkOutput("reset_miso", {31'd0, MISO}, 32'd0);
        checkOutput("reset_vld", {31'd0, cmd_vld}, 32'd0);
        checkOutput("reset_err", {31'd0, frm_err}, 32'd0);
        checkOutput("reset_chnnl", 32'(cmd_chnnl), 32'd0);
        checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
        rst_n = 1'b1;
        wait_clk(4);

        $display("[TB] first frame, channel 3");
        frame_and_check(16'h1800, 16, 10, 1'b1, "f1_ch3");

        $display("[TB] change ch3 before reply frame, command channel 4");
        ch[3] = 12'h555;
        frame_and_check(16'h2000, 16, 10, 1'b1, "f2_ch4");
        frame_and_check(16'h1800, 16, 10, 1'b1, "f3_ch3");

        $display("[TB] short frame");
        frame_and_check(16'h3800, 10, 10, 1'b1, "short");
        frame_and_check(16'h0000, 16, 10, 1'b1, "after_short");

        $display("[TB] reset at bit 7");
        v0 = vld_cnt;
        e0 = err_cnt;
        applyStimulus(16'h2000, 16, 10, 7, rd);
        model_hold  = '0;
        model_chnnl = '0;
        checkOutput("rst_frame_miso", 32'(rd & 16'h01FF), 32'd0);
        checkOutput("rst_frame_vld", 32'(vld_cnt - v0), 32'd0);
        checkOutput("rst_frame_err", 32'(err_cnt - e0), 32'd0);
        checkOutput("rst_frame_chnnl", 32'(cmd_chnnl), 32'd0);
        frame_and_check(16'h3800, 16, 10, 1'b1, "post_rst_ch7");

        $display("[TB] back-to-back frames over all channels");
        v0 = vld_cnt;
        e0 = err_cnt;
        for (int c = 0; c < NUM_CH; c++) begin
            frame_and_check(16'(c) << 11, 16, 4, 1'b0, $sformatf("b2b_ch%0d", c));
        end
        frame_and_check(16'h0000, 16, 10, 1'b0, "b2b_last");
        wait_clk(4);
        checkOutput("b2b_vld_total", 32'(vld_cnt - v0), 32'd9);
        checkOutput("b2b_err_total", 32'(err_cnt - e0), 32'd0);
        checkOutput("b2b_chnnl", 32'(cmd_chnnl), 32'(model_chnnl));
        checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
